replay_ctrl: RTL and testbench

Transmit-side sequencer for the TLP CRC/sequence-number datapath. It accepts 96-bit TLPs, assigns 12-bit sequence numbers, and drives the external LFSR CRC engine through a start/done handshake. Each completed 128-bit frame {4'b0, seq, tlp, crc} is stored in a small replay buffer and sent downstream. ACK/NAK DLLP results purge the buffer, and NAKs or replay-timer timeouts replay every unacknowledged frame.

---
 rtl/replay_ctrl_if.sv | 37 +++
 rtl/replay_ctrl.sv | 141 ++++++++++++++
 tb/tb_replay_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/replay_ctrl_if.sv
// replay_ctrl_if: TLP intake, CRC engine, transmit and ACK/NAK bundle.
// master = surrounding datapath, slave = replay_ctrl.
interface replay_ctrl_if;
  logic         tlp_valid;
  logic [95:0]  tlp_data;
  logic         tlp_ready;
  logic         crc_start;
  logic [127:0] crc_data;
  logic         crc_done;
  logic [15:0]  crc_value;
  logic         tx_valid;
  logic [127:0] tx_data;
  logic         tx_ready;
  logic         ack_valid;
  logic         ack_nak;
  logic [11:0]  ack_seq;

  modport master (
    output tlp_valid, tlp_data,
    input  tlp_ready,
    input  crc_start, crc_data,
    output crc_done, crc_value,
    input  tx_valid, tx_data,
    output tx_ready,
    output ack_valid, ack_nak, ack_seq
  );

  modport slave (
    input  tlp_valid, tlp_data,
    output tlp_ready,
    output crc_start, crc_data,
    input  crc_done, crc_value,
    output tx_valid, tx_data,
    input  tx_ready,
    input  ack_valid, ack_nak, ack_seq
  );
endinterface

// File: rtl/replay_ctrl.sv
// replay_ctrl: TLP sequencer with CRC handshake, replay buffer, ACK/NAK replay.
// Ports: clk, rst (async high), bus (slave), replay_active, next_seq, acked_seq, count, retrain.
module replay_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  replay_ctrl_if.slave           bus,
  output logic                   replay_active,
  output logic [11:0]            next_seq,
  output logic [11:0]            acked_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   retrain
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CRC_WAIT, SEND, REPLAY} state_t;
  state_t state, state_nx;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] ofs, ofs_adv, ofs_nx, count_nx, n_c;
  logic [11:0]   cur_seq, n;
  logic [95:0]   cur_tlp;
  logic [1:0]    replay_num, rn_base;
  logic [TW-1:0] timer;
  logic          crc_first, replay_pend;
  logic          purge, accept, write, enter, tmo, rp_hs, rp_more, nak_trig;
  logic          tlp_ready, tx_valid, crc_start;
  logic [127:0]  tx_data;

  // n is checked against the pre-write count so a frame landing in
  // the same cycle can never be acknowledged early.
  assign n       = bus.ack_seq - acked_seq;
  assign n_c     = CW'(n);
  assign purge   = bus.ack_valid && (n != 12'd0) && (n <= 12'(count));
  assign accept  = bus.tlp_valid && tlp_ready;
  assign write   = (state == CRC_WAIT) && bus.crc_done;
  assign rp_more = (ofs != count);
  assign rp_hs   = (state == REPLAY) && rp_more && bus.tx_ready;
  assign ofs_adv = ofs + CW'(rp_hs);
  assign ofs_nx  = !purge ? ofs_adv :
                   (ofs_adv > n_c) ? ofs_adv - n_c : '0;
  assign count_nx = count + CW'(write) - (purge ? n_c : '0);
  assign rn_base  = purge ? 2'd0 : replay_num;
  assign nak_trig = bus.ack_valid && bus.ack_nak && (count_nx != '0);
  assign tmo = (state != REPLAY) && (count != '0) && !purge &&
               (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    tlp_ready = 1'b0;
    crc_start = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    enter     = 1'b0;
    unique case (state)
      IDLE: begin
        tlp_ready = !replay_pend && (count < CW'(DEPTH));
        if (replay_pend) begin
          state_nx = REPLAY;
          enter    = 1'b1;
        end else if (bus.tlp_valid && tlp_ready) begin
          state_nx = CRC_WAIT;
        end
      end
      CRC_WAIT: begin
        crc_start = crc_first;
        if (bus.crc_done) state_nx = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = mem[wr_ptr - AW'(1)];
        if (bus.tx_ready) state_nx = IDLE;
      end
      REPLAY: begin
        tx_valid = rp_more;
        if (rp_more) tx_data = mem[rd_ptr + ofs[AW-1:0]];
        if (ofs_nx == count_nx) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_seq     <= '0;
      cur_tlp     <= '0;
      crc_first   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ofs         <= '0;
      next_seq    <= '0;
      acked_seq   <= 12'hFFF;
      replay_num  <= '0;
      replay_pend <= 1'b0;
      retrain     <= 1'b0;
      timer       <= '0;
    end else begin
      state     <= state_nx;
      crc_first <= accept;
      count     <= count_nx;
      if (accept) begin
        cur_tlp  <= bus.tlp_data;
        cur_seq  <= next_seq;
        next_seq <= next_seq + 12'd1;
      end
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (purge) begin
        rd_ptr    <= rd_ptr + n[AW-1:0];
        acked_seq <= bus.ack_seq;
      end
      if (enter) ofs <= '0;
      else if (state == REPLAY) ofs <= ofs_nx;
      if (enter) replay_num <= rn_base + 2'd1;
      else if (purge) replay_num <= '0;
      retrain <= enter && (rn_base == 2'd3);
      // Triggers seen during REPLAY or on the entry cycle are dropped.
      if (enter) replay_pend <= 1'b0;
      else if ((nak_trig || tmo) && state != REPLAY) replay_pend <= 1'b1;
      if (purge || enter || count == '0 || tmo) timer <= '0;
      else if (state != REPLAY) timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= {4'b0, cur_seq, cur_tlp, bus.crc_value};
  end

  assign bus.tlp_ready = tlp_ready;
  assign bus.crc_start = crc_start;
  assign bus.crc_data  = {4'b0, cur_seq, cur_tlp, 16'b0};
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign replay_active = (state == REPLAY);
endmodule

// File: tb/tb_replay_ctrl.sv
// tb_replay_ctrl: directed bench for replay_ctrl.
// Bench plays the CRC engine, the downstream sink and the ACK/NAK source.
module tb_replay_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  logic        clk;
  logic        rst;
  logic        replay_active;
  logic        retrain;
  logic [11:0] next_seq;
  logic [11:0] acked_seq;
  logic [2:0]  count;
  int n_cmp;
  int n_bad;

  replay_ctrl_if bus();

  replay_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .replay_active(replay_active),
    .next_seq(next_seq),
    .acked_seq(acked_seq),
    .count(count),
    .retrain(retrain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] crc_f(input logic [95:0] d);
    return d[15:0] ^ d[95:80] ^ 16'h1D0F;
  endfunction

  function automatic logic [127:0] frame_f(input logic [11:0] s, input logic [95:0] d);
    return {4'h0, s, d, crc_f(d)};
  endfunction

  function automatic logic [95:0] mk(input int i);
    return {32'hA5A5_0000 ^ 32'(i), 32'h1234_5678 + 32'(i * 7), 32'hDEAD_BEEF ^ 32'(i * 13)};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tlp_valid = 1'b0;
    bus.tlp_data  = '0;
    bus.crc_done  = 1'b0;
    bus.crc_value = '0;
    bus.tx_ready  = 1'b1;
    bus.ack_valid = 1'b0;
    bus.ack_nak   = 1'b0;
    bus.ack_seq   = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic send_tlp(input logic [95:0] d, output logic [127:0] fr, output int lat,
                          output logic st, output logic [127:0] cd);
    int k;
    bus.tlp_valid = 1'b1;
    bus.tlp_data  = d;
    bus.crc_done  = 1'b1;
    bus.crc_value = crc_f(d);
    k = 0;
    while (!bus.tlp_ready && k < 50) begin
      cyc();
      k++;
    end
    if (!bus.tlp_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_accept: tlp_ready stayed %b, required 1", bus.tlp_ready);
    end
    cyc();
    bus.tlp_valid = 1'b0;
    st  = bus.crc_start;
    cd  = bus.crc_data;
    lat = -1;
    fr  = '0;
    for (int i = 1; i < 20; i++) begin
      if (bus.tx_valid) begin
        lat = i;
        fr  = bus.tx_data;
        break;
      end
      cyc();
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL send_tx: tx_valid never rose, required within 20 cycles");
    end
    cyc();
  endtask

  task automatic send_ack(input logic nak, input logic [11:0] s);
    bus.ack_valid = 1'b1;
    bus.ack_nak   = nak;
    bus.ack_seq   = s;
    cyc();
    bus.ack_valid = 1'b0;
    bus.ack_nak   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.tlp_ready !== 1'b1) begin n_bad++; $display("FAIL rst_tlp_ready: got %b want 1", bus.tlp_ready); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 128'h0) begin n_bad++; $display("FAIL rst_tx_data: got %h want 0", bus.tx_data); end
    n_cmp++; if (bus.crc_start !== 1'b0) begin n_bad++; $display("FAIL rst_crc_start: got %b want 0", bus.crc_start); end
    n_cmp++; if (bus.crc_data !== 128'h0) begin n_bad++; $display("FAIL rst_crc_data: got %h want 0", bus.crc_data); end
    n_cmp++; if (replay_active !== 1'b0) begin n_bad++; $display("FAIL rst_replay_active: got %b want 0", replay_active); end
    n_cmp++; if (retrain !== 1'b0) begin n_bad++; $display("FAIL rst_retrain: got %b want 0", retrain); end
    n_cmp++; if (next_seq !== 12'd0) begin n_bad++; $display("FAIL rst_next_seq: got %0d want 0", next_seq); end
    n_cmp++; if (acked_seq !== 12'd4095) begin n_bad++; $display("FAIL rst_acked_seq: got %0d want 4095", acked_seq); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
  endtask

  task automatic test_basic();
    logic [127:0] fr, cd;
    logic st;
    int lat;
    do_reset();
    send_tlp(mk(1), fr, lat, st, cd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL basic_lat_a: got %0d want 2", lat); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL basic_crc_start: got %b want 1", st); end
    n_cmp++; if (cd !== {4'h0, 12'd0, mk(1), 16'h0}) begin n_bad++; $display("FAIL basic_crc_data: got %h want %h", cd, {4'h0, 12'd0, mk(1), 16'h0}); end
    n_cmp++; if (fr !== frame_f(12'd0, mk(1))) begin n_bad++; $display("FAIL basic_frame_a: got %h want %h", fr, frame_f(12'd0, mk(1))); end
    send_tlp(mk(2), fr, lat, st, cd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL basic_lat_b: got %0d want 2", lat); end
    n_cmp++; if (fr !== frame_f(12'd1, mk(2))) begin n_bad++; $display("FAIL basic_frame_b: got %h want %h", fr, frame_f(12'd1, mk(2))); end
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", count); end
    n_cmp++; if (next_seq !== 12'd2) begin n_bad++; $display("FAIL basic_next_seq: got %0d want 2", next_seq); end
  endtask

  task automatic test_fill();
    logic [127:0] fr, cd;
    logic st;
    int lat;
    do_reset();
    for (int i = 0; i < 4; i++) send_tlp(mk(10 + i), fr, lat, st, cd);
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", count); end
    n_cmp++; if (bus.tlp_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_full: got %b want 0", bus.tlp_ready); end
    send_ack(1'b0, 12'd1);
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL fill_ack_count: got %0d want 2", count); end
    n_cmp++; if (acked_seq !== 12'd1) begin n_bad++; $display("FAIL fill_acked_seq: got %0d want 1", acked_seq); end
    n_cmp++; if (bus.tlp_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_after: got %b want 1", bus.tlp_ready); end
  endtask

  task automatic test_nak();
    logic [127:0] fr [4];
    logic [127:0] cd;
    logic st;
    int lat, got;
    logic seen;
    do_reset();
    for (int i = 0; i < 4; i++) send_tlp(mk(20 + i), fr[i], lat, st, cd);
    send_ack(1'b1, 12'd0);
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL nak_count: got %0d want 3", count); end
    got = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (replay_active) begin
        seen = 1'b1;
        if (got < 3) begin
          n_cmp++;
          if (!(bus.tx_valid === 1'b1 && bus.tx_data === fr[got + 1])) begin
            n_bad++;
            $display("FAIL nak_replay_%0d: got v=%b %h want v=1 %h", got, bus.tx_valid, bus.tx_data, fr[got + 1]);
          end
        end
        got++;
      end else if (seen) begin
        break;
      end
      cyc();
    end
    n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL nak_replay_len: got %0d want 3", got); end
    n_cmp++; if (replay_active !== 1'b0) begin n_bad++; $display("FAIL nak_exit: got %b want 0", replay_active); end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL nak_count_after: got %0d want 3", count); end
  endtask

  task automatic test_timeout();
    logic [127:0] fr, cd;
    logic st;
    int lat, w;
    do_reset();
    send_tlp(mk(30), fr, lat, st, cd);
    for (int e = 1; e <= 4; e++) begin
      w = 0;
      while (!replay_active && w < 200) begin
        cyc();
        w++;
      end
      if (e == 1) begin
        n_cmp++; if (w !== TIMEOUT) begin n_bad++; $display("FAIL tmo_wait: got %0d want %0d", w, TIMEOUT); end
      end
      n_cmp++; if (replay_active !== 1'b1) begin n_bad++; $display("FAIL tmo_entry_%0d: got %b want 1", e, replay_active); end
      n_cmp++; if (retrain !== (e == 4)) begin n_bad++; $display("FAIL tmo_retrain_%0d: got %b want %b", e, retrain, e == 4); end
      n_cmp++; if (bus.tx_data !== fr) begin n_bad++; $display("FAIL tmo_frame_%0d: got %h want %h", e, bus.tx_data, fr); end
      cyc();
    end
    n_cmp++; if (retrain !== 1'b0) begin n_bad++; $display("FAIL tmo_retrain_pulse: got %b want 0", retrain); end
  endtask

  task automatic test_wrap();
    logic [127:0] fr, cd;
    logic st;
    int lat;
    logic [11:0] s;
    do_reset();
    for (int i = 0; i < 4094; i++) begin
      send_tlp(mk(i), fr, lat, st, cd);
      send_ack(1'b0, 12'(i));
    end
    n_cmp++; if (next_seq !== 12'd4094) begin n_bad++; $display("FAIL wrap_next_seq: got %0d want 4094", next_seq); end
    n_cmp++; if (acked_seq !== 12'd4093) begin n_bad++; $display("FAIL wrap_acked_pre: got %0d want 4093", acked_seq); end
    for (int i = 0; i < 4; i++) begin
      s = 12'd4094 + 12'(i);
      send_tlp(mk(100 + i), fr, lat, st, cd);
      n_cmp++; if (fr !== frame_f(s, mk(100 + i))) begin n_bad++; $display("FAIL wrap_frame_%0d: got %h want %h", i, fr, frame_f(s, mk(100 + i))); end
    end
    n_cmp++; if (next_seq !== 12'd2) begin n_bad++; $display("FAIL wrap_next_seq2: got %0d want 2", next_seq); end
    send_ack(1'b0, 12'd0);
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL wrap_ack_count: got %0d want 1", count); end
    n_cmp++; if (acked_seq !== 12'd0) begin n_bad++; $display("FAIL wrap_acked: got %0d want 0", acked_seq); end
    send_ack(1'b0, 12'd0);
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL wrap_dup_count: got %0d want 1", count); end
    n_cmp++; if (acked_seq !== 12'd0) begin n_bad++; $display("FAIL wrap_dup_acked: got %0d want 0", acked_seq); end
    send_ack(1'b0, 12'd3);
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL wrap_oow_count: got %0d want 1", count); end
  endtask

  task automatic test_replay_purge();
    logic [127:0] fr [4];
    logic [127:0] cd;
    logic st;
    int lat, w;
    do_reset();
    for (int i = 0; i < 4; i++) send_tlp(mk(40 + i), fr[i], lat, st, cd);
    send_ack(1'b1, 12'd4095);
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL rp_dup_nak_count: got %0d want 4", count); end
    w = 0;
    while (!replay_active && w < 10) begin
      cyc();
      w++;
    end
    n_cmp++; if (!(replay_active === 1'b1 && bus.tx_data === fr[0])) begin n_bad++; $display("FAIL rp_first: got a=%b %h want a=1 %h", replay_active, bus.tx_data, fr[0]); end
    cyc();
    n_cmp++; if (bus.tx_data !== fr[1]) begin n_bad++; $display("FAIL rp_second: got %h want %h", bus.tx_data, fr[1]); end
    send_ack(1'b0, 12'd2);
    n_cmp++; if (replay_active !== 1'b1) begin n_bad++; $display("FAIL rp_still_active: got %b want 1", replay_active); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL rp_count: got %0d want 1", count); end
    n_cmp++; if (bus.tx_data !== fr[3]) begin n_bad++; $display("FAIL rp_clamp_frame: got %h want %h", bus.tx_data, fr[3]); end
    cyc();
    n_cmp++; if (replay_active !== 1'b0) begin n_bad++; $display("FAIL rp_exit: got %b want 0", replay_active); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.tx_ready  = 1'b0;
    bus.tlp_valid = 1'b1;
    bus.tlp_data  = mk(77);
    bus.crc_done  = 1'b1;
    bus.crc_value = crc_f(mk(77));
    cyc();
    bus.tlp_valid = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (!(bus.tx_valid === 1'b1 && count === 3'd1)) begin n_bad++; $display("FAIL mid_in_send: got v=%b c=%0d want v=1 c=1", bus.tx_valid, count); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_tx_valid: got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 128'h0) begin n_bad++; $display("FAIL mid_tx_data: got %h want 0", bus.tx_data); end
    n_cmp++; if (bus.crc_data !== 128'h0) begin n_bad++; $display("FAIL mid_crc_data: got %h want 0", bus.crc_data); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", count); end
    n_cmp++; if (bus.tlp_ready !== 1'b1) begin n_bad++; $display("FAIL mid_tlp_ready: got %b want 1", bus.tlp_ready); end
    n_cmp++; if (next_seq !== 12'd0) begin n_bad++; $display("FAIL mid_next_seq: got %0d want 0", next_seq); end
    n_cmp++; if (acked_seq !== 12'd4095) begin n_bad++; $display("FAIL mid_acked_seq: got %0d want 4095", acked_seq); end
    n_cmp++; if (replay_active !== 1'b0) begin n_bad++; $display("FAIL mid_replay_active: got %b want 0", replay_active); end
    cyc();
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    cyc();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_fill();
    test_nak();
    test_timeout();
    test_replay_purge();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
